// File: rtl/ctrl_aut_pkg.sv
// Shared definitions for the access-control block: FSM states, default timing
// parameters and the width helper for the shared hold/lockout counter.
package ctrl_aut_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AVALIA    = 3'd1,
    CONCEDIDO = 3'd2,
    NEGADO    = 3'd3,
    BLOQUEADO = 3'd4
  } estado_t;

  localparam int T_CONCEDIDO_DEF = 4;
  localparam int T_BLOQUEIO_DEF  = 16;
  localparam int MAX_FALHAS_DEF  = 3;

  localparam int CODIGO_W  = 3;
  localparam int RECURSO_W = 3;
  localparam int FALHAS_W  = 2;
  localparam int PERM_W    = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit so the counter can hold the full duration itself.
  function automatic int cnt_width(input int t_a, input int t_b);
    return $clog2(max_int(t_a, t_b)) + 1;
  endfunction

endpackage

// File: rtl/controle_autenticacao_if.sv
// Request/response bundle between a requester and the access controller.
import ctrl_aut_pkg::*;

interface controle_autenticacao_if;
  logic                 req;
  logic [CODIGO_W-1:0]  codigo;
  logic [RECURSO_W-1:0] recurso;
  logic                 concedido;
  logic                 negado;
  logic                 bloqueado;
  logic                 ocupado;
  logic [FALHAS_W-1:0]  falhas;
  logic [PERM_W-1:0]    permissoes;

  modport master (
    output req, codigo, recurso,
    input  concedido, negado, bloqueado, ocupado, falhas, permissoes
  );

  modport slave (
    input  req, codigo, recurso,
    output concedido, negado, bloqueado, ocupado, falhas, permissoes
  );
endinterface

// File: rtl/matriz_permissoes.sv
// Combinational permission table: maps a user code {A,B,C} to the resource
// vector {P7..P1}.
import ctrl_aut_pkg::*;

module matriz_permissoes (
  input  logic [CODIGO_W-1:0] codigo,
  output logic [PERM_W-1:0]   permissoes
);

  logic a;
  logic b;
  logic c;

  assign a = codigo[2];
  assign b = codigo[1];
  assign c = codigo[0];

  assign permissoes = {a & ~b,   // P7
                       1'b1,     // P6
                       a & ~b,   // P5
                       c,        // P4
                       c,        // P3
                       a ^ b,    // P2
                       1'b1};    // P1

endmodule

// File: rtl/controle_autenticacao.sv
// Access-control FSM: evaluates a latched code against the permission table,
// then grants, denies, or locks out after repeated consecutive denials.
import ctrl_aut_pkg::*;

module controle_autenticacao #(
  parameter int T_CONCEDIDO = T_CONCEDIDO_DEF,
  parameter int T_BLOQUEIO  = T_BLOQUEIO_DEF,
  parameter int MAX_FALHAS  = MAX_FALHAS_DEF
) (
  input logic                     clk,
  input logic                     rst,
  controle_autenticacao_if.slave  aut
);

  localparam int CNT_W = cnt_width(T_CONCEDIDO, T_BLOQUEIO);
  localparam logic [CNT_W-1:0]    CNT_CONCEDIDO = CNT_W'(T_CONCEDIDO);
  localparam logic [CNT_W-1:0]    CNT_BLOQUEIO  = CNT_W'(T_BLOQUEIO);
  localparam logic [FALHAS_W-1:0] MAX_F         = FALHAS_W'(MAX_FALHAS);

  estado_t               estado;
  estado_t               estado_n;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_n;
  logic [FALHAS_W-1:0]   falhas_q;
  logic [FALHAS_W-1:0]   falhas_n;
  logic [FALHAS_W-1:0]   falha_inc;
  logic [PERM_W-1:0]     perm_q;
  logic [PERM_W-1:0]     perm_n;
  logic [PERM_W-1:0]     perm_tab;
  logic [PERM_W:0]       perm_ext;
  logic                  permitido;
  logic                  concedido_q;
  logic                  negado_q;
  logic                  bloqueado_q;
  logic                  ocupado_q;

  // Request stage: code and resource captured at the accepting edge
  logic [CODIGO_W-1:0]   codigo_p0;
  logic [RECURSO_W-1:0]  recurso_p0;

  always_ff @(posedge clk) begin
    if (estado == IDLE && aut.req) begin
      codigo_p0  <= aut.codigo;
      recurso_p0 <= aut.recurso;
    end
  end

  matriz_permissoes u_matriz (
    .codigo     (codigo_p0),
    .permissoes (perm_tab)
  );

  // Bit 0 is a hard zero so resource index 0 naturally reads as "not allowed".
  assign perm_ext  = {perm_tab, 1'b0};
  assign permitido = perm_ext[recurso_p0];

  always_comb begin
    estado_n  = estado;
    cnt_n     = cnt;
    falhas_n  = falhas_q;
    perm_n    = perm_q;
    falha_inc = (falhas_q >= MAX_F) ? MAX_F : falhas_q + 2'd1;

    unique case (estado)
      IDLE: begin
        if (aut.req) estado_n = AVALIA;
      end

      AVALIA: begin
        perm_n = perm_tab;
        if (permitido) begin
          estado_n = CONCEDIDO;
          cnt_n    = CNT_CONCEDIDO;
          falhas_n = '0;
        end else begin
          estado_n = NEGADO;
          falhas_n = falha_inc;
        end
      end

      NEGADO: begin
        if (falhas_q == MAX_F) begin
          estado_n = BLOQUEADO;
          cnt_n    = CNT_BLOQUEIO;
        end else begin
          estado_n = IDLE;
        end
      end

      CONCEDIDO, BLOQUEADO: begin
        // Counter was loaded with the full duration on entry; leave on the last cycle.
        if (cnt <= CNT_W'(1)) begin
          estado_n = IDLE;
          cnt_n    = '0;
          if (estado == BLOQUEADO) falhas_n = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        estado_n = IDLE;
        cnt_n    = '0;
      end
    endcase
  end

  // State stage: outputs are decoded from the next state so they are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= IDLE;
      cnt         <= '0;
      falhas_q    <= '0;
      perm_q      <= '0;
      concedido_q <= 1'b0;
      negado_q    <= 1'b0;
      bloqueado_q <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado      <= estado_n;
      cnt         <= cnt_n;
      falhas_q    <= falhas_n;
      perm_q      <= perm_n;
      concedido_q <= (estado_n == CONCEDIDO);
      negado_q    <= (estado_n == NEGADO);
      bloqueado_q <= (estado_n == BLOQUEADO);
      ocupado_q   <= (estado_n != IDLE);
    end
  end

  assign aut.concedido  = concedido_q;
  assign aut.negado     = negado_q;
  assign aut.bloqueado  = bloqueado_q;
  assign aut.ocupado    = ocupado_q;
  assign aut.falhas     = falhas_q;
  assign aut.permissoes = perm_q;

endmodule

// File: doc/controle_autenticacao.md
CONTROLE_AUTENTICACAO -- requirements
Module: controle_autenticacao

Interface
REQ-001 Parameter T_CONCEDIDO, default 4, SHALL set the number of cycles a grant is held.
REQ-002 Parameter T_BLOQUEIO, default 16, SHALL set the number of lockout cycles.
REQ-003 Parameter MAX_FALHAS, default 3, SHALL set the number of consecutive denials that triggers lockout.
REQ-004 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 req  in  1  access request, level-sampled, honoured only in IDLE.
REQ-007 codigo  in  3  user code, with bit2=A, bit1=B, bit0=C.
REQ-008 recurso  in  3  requested resource index 1..7 (P1..P7); 0 is invalid.
REQ-009 concedido  out  1  access granted, held high for T_CONCEDIDO cycles.
REQ-010 negado  out  1  one-cycle denial pulse.
REQ-011 bloqueado  out  1  high during lockout.
REQ-012 ocupado  out  1  high in every state except IDLE.
REQ-013 falhas  out  2  consecutive-denial count.
REQ-014 permissoes  out  7  registered permission vector {P7..P1} of the last evaluated code.

Function
REQ-015 Permission table SHALL be:
- P1 = 1
- P2 = A xor B
- P3 = C
- P4 = C
- P5 = A and not B
- P6 = 1
- P7 = A and not B
REQ-016 The FSM SHALL have the states IDLE, AVALIA, CONCEDIDO, NEGADO and BLOQUEADO, with all outputs registered.
REQ-017 IDLE with req=1 at an edge SHALL move to AVALIA and latch codigo and recurso at that same edge; req in any other state SHALL be ignored, with no queuing.
REQ-018 AVALIA SHALL last 1 cycle and load permissoes from the latched code.
- Grant when recurso is nonzero and bit (recurso-1) of the table is 1.
- Otherwise deny.
REQ-019 On grant, concedido SHALL rise at the edge leaving AVALIA and stay high exactly T_CONCEDIDO cycles; falhas SHALL clear to 0; the FSM then returns to IDLE.
REQ-020 On deny, negado SHALL be high exactly 1 cycle (NEGADO) and falhas SHALL increment.
- If the incremented value equals MAX_FALHAS, the next state is BLOQUEADO.
- Otherwise the next state is IDLE.
REQ-021 BLOQUEADO SHALL hold bloqueado=1 for exactly T_BLOQUEIO cycles, then clear falhas to 0 and return to IDLE.
REQ-022 Latency SHALL be fixed: req accepted at edge k gives a decision visible after edge k+1; the next req is accepted no earlier than the first edge with the FSM in IDLE.
REQ-023 A single cycle-down counter SHALL serve CONCEDIDO and BLOQUEADO, sized clog2(max(T_CONCEDIDO,T_BLOQUEIO))+1, and SHALL load on state entry.
REQ-024 falhas SHALL saturate at MAX_FALHAS and never wrap.
REQ-025 Invalid recurso=0 SHALL count as a denial.
REQ-026 concedido, negado and bloqueado SHALL be mutually exclusive in every cycle.

Reset
REQ-027 rst=1 SHALL immediately force:
- state = IDLE
- concedido = negado = bloqueado = ocupado = 0
- falhas = 0
- permissoes = 0
- counter = 0
REQ-028 Reset mid-grant or mid-lockout SHALL abort the operation with no residual pulse after deassertion.
REQ-029 The first req SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-030 Shared package ctrl_aut_pkg SHALL hold the state enum and the default values of T_CONCEDIDO, T_BLOQUEIO and MAX_FALHAS.
REQ-031 The permission table SHALL be a combinational sub-module matriz_permissoes (codigo in, 7-bit vector out), instantiated once.

Verification
REQ-032 codigo=3'b100, recurso=5, req pulse -> permissoes=7'b1110011, concedido high 4 cycles starting 1 cycle after acceptance, falhas=0.
REQ-033 codigo=3'b000, recurso=3 -> negado 1-cycle pulse, falhas=1, permissoes=7'b0100001.
REQ-034 Three consecutive denials (codigo=3'b000, recurso=2) -> third gives negado then bloqueado high 16 cycles, req ignored throughout, falhas=0 afterwards.
REQ-035 Two denials then a grant (codigo=3'b001, recurso=4) -> falhas goes 1, 2, then 0, with no lockout.
REQ-036 recurso=0 with codigo=3'b111 -> negado pulse.
REQ-037 req held high continuously during CONCEDIDO -> a new evaluation starts only at the first edge in IDLE.
REQ-038 rst asserted in cycle 2 of BLOQUEADO -> all outputs 0 asynchronously, and an immediate req after release is accepted.
